wt_mem_arbiter: RTL

WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

---
 rtl/config_pkg.sv | 11 +
 rtl/wt_cache_pkg.sv | 14 +
 rtl/wt_outstanding_cnt.sv | 42 ++++
 rtl/wt_mem_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Minimal core-configuration package: carries the configuration record handed to
// cache-subsystem blocks so they elaborate standalone.
package config_pkg;

  typedef struct packed {
    logic [31:0] XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};

endpackage : config_pkg

// File: rtl/wt_cache_pkg.sv
// Shared definitions for the write-through cache memory arbiter: requester
// source encoding and a helper to flip between the two sources.
package wt_cache_pkg;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ICACHE) ? SRC_DCACHE : SRC_ICACHE;
  endfunction

endpackage : wt_cache_pkg

// File: rtl/wt_outstanding_cnt.sv
// Per-requester in-flight counter: counts accepted requests minus routed returns,
// saturating at zero and flagging a return that arrives with nothing outstanding.
module wt_outstanding_cnt #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o,
  output logic underflow_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: next-state gets its hold value first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o      = (cnt_q == CntWidth'(MaxOutstanding));
  assign zero_o      = (cnt_q == '0);
  assign underflow_o = dec_i && zero_o;

endmodule : wt_outstanding_cnt

// File: rtl/wt_mem_arbiter.sv
// Two-way round-robin arbiter between I$ and D$ towards the memory adapter, with
// grant locking until accepted, per-source outstanding limits and return routing.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
  parameter int unsigned           ReqWidth       = 64,
  parameter int unsigned           MaxOutstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                icache_data_req_i,
  output logic                icache_data_ack_o,
  input  logic [ReqWidth-1:0] icache_data_i,
  input  logic                dcache_data_req_i,
  output logic                dcache_data_ack_o,
  input  logic [ReqWidth-1:0] dcache_data_i,
  output logic                mem_req_o,
  input  logic                mem_ack_i,
  output logic [ReqWidth-1:0] mem_data_o,
  output logic                mem_src_o,
  input  logic                mem_rtrn_vld_i,
  input  logic                mem_rtrn_src_i,
  output logic                icache_rtrn_vld_o,
  output logic                dcache_rtrn_vld_o,
  input  logic                drain_i,
  output logic                idle_o,
  output logic                err_o
);

  if (MaxOutstanding < 1 || CVA6Cfg.XLEN == 32'd0) begin : g_bad_cfg
    $error("wt_mem_arbiter: invalid configuration");
  end

  src_e       grant_src;
  src_e       rr_q, rr_d;
  src_e       lock_src_q, lock_src_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic       mem_req, handshake, protocol_err;
  logic [1:0] req, elig, full, zero, underflow, inc, dec;

  assign req  = {dcache_data_req_i, icache_data_req_i};
  assign elig = req & ~full & {2{~drain_i}};

  // A locked grant ignores eligibility: the adapter has already seen this request.
  always_comb begin
    grant_src = SRC_ICACHE;
    mem_req   = 1'b0;
    if (lock_q) begin
      grant_src = lock_src_q;
      mem_req   = req[lock_src_q];
    end else begin
      mem_req = |elig;
      if (&elig) begin
        grant_src = rr_q;
      end else if (elig[SRC_DCACHE]) begin
        grant_src = SRC_DCACHE;
      end
    end
  end

  assign handshake    = mem_req && mem_ack_i;
  assign protocol_err = lock_q && !req[lock_src_q];

  assign inc = {handshake && (grant_src == SRC_DCACHE), handshake && (grant_src == SRC_ICACHE)};
  assign dec = {mem_rtrn_vld_i && mem_rtrn_src_i, mem_rtrn_vld_i && !mem_rtrn_src_i};

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    wt_outstanding_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) i_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (inc[g]),
      .dec_i      (dec[g]),
      .full_o     (full[g]),
      .zero_o     (zero[g]),
      .underflow_o(underflow[g])
    );
  end

  // A dropped locked request forces mem_req low, which also releases the lock.
  assign lock_d     = mem_req && !mem_ack_i;
  assign lock_src_d = grant_src;
  assign rr_d       = handshake ? other_src(grant_src) : rr_q;
  assign err_d      = err_q || protocol_err || (|underflow);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= SRC_ICACHE;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_ICACHE;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_o  = mem_req;
  assign mem_src_o  = mem_req && (grant_src == SRC_DCACHE);
  assign mem_data_o = !mem_req ? '0 :
                      (grant_src == SRC_DCACHE) ? dcache_data_i : icache_data_i;

  assign icache_data_ack_o = inc[SRC_ICACHE];
  assign dcache_data_ack_o = inc[SRC_DCACHE];
  assign icache_rtrn_vld_o = dec[SRC_ICACHE];
  assign dcache_rtrn_vld_o = dec[SRC_DCACHE];

  assign idle_o = (&zero) && !lock_q;
  assign err_o  = err_q;

endmodule : wt_mem_arbiter
